// File: rtl/psg_mix_sd_dac_if.sv
// Mixer control/data bundle for psg_mix_sd_dac; vol_l/vol_r exist only with PSG_MIX_VOLUME_EN.
interface psg_mix_sd_dac_if #(
    parameter int unsigned NCH = 3,
    parameter int unsigned IW  = 8
);
    localparam int unsigned OW = IW + $clog2(NCH);

    logic              ce_sample;
    logic [NCH*IW-1:0] ch_in;
    logic [2*NCH-1:0]  pan_map;
    logic [1:0]        mode;
    logic              clr_overrun;
`ifdef PSG_MIX_VOLUME_EN
    logic [3:0]        vol_l;
    logic [3:0]        vol_r;
`endif
    logic [OW-1:0]     mix_l;
    logic [OW-1:0]     mix_r;
    logic              mix_valid;
    logic              busy;
    logic              overrun;
    logic              dac_l;
    logic              dac_r;

`ifdef PSG_MIX_VOLUME_EN
    modport master (output ce_sample, ch_in, pan_map, mode, clr_overrun, vol_l, vol_r,
                    input  mix_l, mix_r, mix_valid, busy, overrun, dac_l, dac_r);
    modport slave  (input  ce_sample, ch_in, pan_map, mode, clr_overrun, vol_l, vol_r,
                    output mix_l, mix_r, mix_valid, busy, overrun, dac_l, dac_r);
`else
    modport master (output ce_sample, ch_in, pan_map, mode, clr_overrun,
                    input  mix_l, mix_r, mix_valid, busy, overrun, dac_l, dac_r);
    modport slave  (input  ce_sample, ch_in, pan_map, mode, clr_overrun,
                    output mix_l, mix_r, mix_valid, busy, overrun, dac_l, dac_r);
`endif
endinterface

// File: rtl/psg_mix_sd_dac.sv
// N-channel sequential PSG stereo mixer with twin first-order sigma-delta DACs.
// Optional per-side volume scaling when PSG_MIX_VOLUME_EN is defined.
module psg_mix_sd_dac #(
    parameter int unsigned NCH = 3,
    parameter int unsigned IW  = 8
) (
    input logic             clk_sys,
    input logic             reset,
    psg_mix_sd_dac_if.slave bus
);
    localparam int unsigned OW   = IW + $clog2(NCH);
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, VOL = 2'd2, DONE = 2'd3} state_t;

    state_t            state, state_nxt;
    logic [NCH*IW-1:0] ch_q, ch_nxt;
    logic [2*NCH-1:0]  pan_q, pan_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [IDXW-1:0]   idx, idx_nxt;
    logic [OW-1:0]     acc_l, acc_r, acc_l_nxt, acc_r_nxt;
    logic [OW-1:0]     mix_l_nxt, mix_r_nxt;
    logic              mix_valid_nxt, overrun_nxt;
    logic [OW:0]       integ_l, integ_r;

    logic [IW-1:0]     sample_c;
    logic [1:0]        code_c;
    logic [OW-1:0]     acc_l_sum_c, acc_r_sum_c;
    logic              last_c;

    // Current channel contribution, with the mode applied to its pan code
    always_comb begin
        sample_c = ch_q[32'(idx) * IW +: IW];
        unique case (mode_q)
            2'b01:   code_c = pan_q[32'(idx) * 2 +: 2];
            2'b10:   code_c = {pan_q[32'(idx) * 2], pan_q[32'(idx) * 2 + 1]};
            default: code_c = 2'b11;
        endcase
        acc_l_sum_c = acc_l + (code_c[0] ? OW'(sample_c) : '0);
        acc_r_sum_c = acc_r + (code_c[1] ? OW'(sample_c) : '0);
        last_c      = (idx == IDXW'(NCH - 1));
    end

`ifdef PSG_MIX_VOLUME_EN
    logic [OW+4:0] scaled_l_c, scaled_r_c;

    always_comb begin
        scaled_l_c = (OW+5)'(acc_l) * (OW+5)'({1'b0, bus.vol_l} + 5'd1);
        scaled_r_c = (OW+5)'(acc_r) * (OW+5)'({1'b0, bus.vol_r} + 5'd1);
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.ce_sample) state_nxt = ACC;
`ifdef PSG_MIX_VOLUME_EN
            ACC:  if (last_c) state_nxt = VOL;
`else
            ACC:  if (last_c) state_nxt = DONE;
`endif
            VOL:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on entry to DONE so mix_valid coincides with the DONE cycle
    always_comb begin
        ch_nxt        = ch_q;
        pan_nxt       = pan_q;
        mode_nxt      = mode_q;
        idx_nxt       = idx;
        acc_l_nxt     = acc_l;
        acc_r_nxt     = acc_r;
        mix_l_nxt     = bus.mix_l;
        mix_r_nxt     = bus.mix_r;
        mix_valid_nxt = 1'b0;
        overrun_nxt   = (bus.ce_sample && state != IDLE) ? 1'b1
                      : (bus.clr_overrun ? 1'b0 : bus.overrun);
        unique case (state)
            IDLE: begin
                if (bus.ce_sample) begin
                    ch_nxt    = bus.ch_in;
                    pan_nxt   = bus.pan_map;
                    mode_nxt  = bus.mode;
                    acc_l_nxt = '0;
                    acc_r_nxt = '0;
                    idx_nxt   = '0;
                end
            end
            ACC: begin
                acc_l_nxt = acc_l_sum_c;
                acc_r_nxt = acc_r_sum_c;
                idx_nxt   = idx + IDXW'(1);
`ifndef PSG_MIX_VOLUME_EN
                if (last_c) begin
                    mix_l_nxt     = acc_l_sum_c;
                    mix_r_nxt     = acc_r_sum_c;
                    mix_valid_nxt = 1'b1;
                end
`endif
            end
            VOL: begin
`ifdef PSG_MIX_VOLUME_EN
                mix_l_nxt     = OW'(scaled_l_c >> 4);
                mix_r_nxt     = OW'(scaled_r_c >> 4);
                mix_valid_nxt = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ch_q          <= '0;
            pan_q         <= '0;
            mode_q        <= '0;
            idx           <= '0;
            acc_l         <= '0;
            acc_r         <= '0;
            bus.mix_l     <= '0;
            bus.mix_r     <= '0;
            bus.mix_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            ch_q          <= ch_nxt;
            pan_q         <= pan_nxt;
            mode_q        <= mode_nxt;
            idx           <= idx_nxt;
            acc_l         <= acc_l_nxt;
            acc_r         <= acc_r_nxt;
            bus.mix_l     <= mix_l_nxt;
            bus.mix_r     <= mix_r_nxt;
            bus.mix_valid <= mix_valid_nxt;
            bus.busy      <= (state_nxt != IDLE);
            bus.overrun   <= overrun_nxt;
        end
    end

    // First-order sigma-delta: the carry out of the OW-bit accumulator is the bitstream
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            integ_l   <= '0;
            integ_r   <= '0;
            bus.dac_l <= 1'b0;
            bus.dac_r <= 1'b0;
        end else begin
            integ_l   <= {1'b0, integ_l[OW-1:0]} + (OW+1)'(bus.mix_l);
            integ_r   <= {1'b0, integ_r[OW-1:0]} + (OW+1)'(bus.mix_r);
            bus.dac_l <= integ_l[OW];
            bus.dac_r <= integ_r[OW];
        end
    end
endmodule
